// File: rtl/hs32_sram_lane_ctl.sv
// ---------------------------------------------------------------------------
// hs32_sram_lane_ctl
//
// Byte-lane SRAM controller for the HS32 core. Serves byte/half/word reads
// and writes at any byte address over four byte-wide SRAM lanes. Lane l
// holds byte l of each 32-bit row. An access that straddles a row boundary
// is split so that lanes below the start offset use the next row (which
// wraps from the top row back to row 0).
//
// Optional feature: define HS32_SRAM_ALIGN_CHK_EN to reject misaligned
// half/word accesses with o_err instead of serving them by rotation.
//
// Parameters
//   ADDR_WIDTH  byte-address width; each lane row address is ADDR_WIDTH-2 bits
//   RD_LAT      macro read latency in cycles (1..4)
//
// Ports
//   i_clk, i_reset_n       clock, synchronous active-low reset
//   i_addr/i_size/i_rw     request: byte address, size (00 b, 01 h, 1x w), 1=write
//   i_dwrite, i_stb        right-justified write data, request strobe
//   o_dread                right-justified, zero-extended read data
//   o_ack, o_busy, o_err   completion pulse, busy flag, misalignment flag
//   o_mem_*                SRAM macro side: per-lane rows, enable, write enable,
//                          per-lane byte mask, per-lane write data
//   i_mem_rdata            SRAM read data, lane l on [8l +: 8]
// ---------------------------------------------------------------------------
module hs32_sram_lane_ctl #(
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    input  logic [1:0]                  i_size,
    input  logic                        i_rw,
    input  logic [31:0]                 i_dwrite,
    input  logic                        i_stb,
    output logic [31:0]                 o_dread,
    output logic                        o_ack,
    output logic                        o_busy,
    output logic                        o_err,
    output logic [4*(ADDR_WIDTH-2)-1:0] o_mem_addr,
    output logic                        o_mem_en,
    output logic                        o_mem_wen,
    output logic [3:0]                  o_mem_wmask,
    output logic [31:0]                 o_mem_wdata,
    input  logic [31:0]                 i_mem_rdata
);

    localparam int RW = ADDR_WIDTH - 2;
    // Last value of the wait counter before moving to capture.
    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    rw_q;
    logic [31:0]             dwrite_q;
    logic [31:0]             dread_q;

    logic [1:0]              off;
    logic [RW-1:0]           row, row_n;
    logic [2:0]              nb;
    logic [1:0]              k;
    logic [1:0]              lane;
    logic [4*RW-1:0]         lane_row;
    logic [3:0]              lane_mask;
    logic [31:0]             lane_wdata;
    logic [31:0]             rd_data;

    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

`ifdef HS32_SRAM_ALIGN_CHK_EN
    logic err_q;

    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Request capture; only taken in IDLE so strobes while busy are dropped.
    always_ff @(posedge i_clk) begin
        if (state_q == S_IDLE && i_stb) begin
            addr_q   <= i_addr;
            size_q   <= i_size;
            rw_q     <= i_rw;
            dwrite_q <= i_dwrite;
        end
    end

`ifdef HS32_SRAM_ALIGN_CHK_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && i_stb) begin
            err_q <= misaligned(i_addr[1:0], i_size);
        end
    end
`endif

    // Read result register; holds across writes until the next read completes.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            dread_q <= 32'd0;
        end else if (state_q == S_CAPT) begin
            dread_q <= rd_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (i_stb) begin
`ifdef HS32_SRAM_ALIGN_CHK_EN
                    // Faulting requests never touch the macros.
                    if (misaligned(i_addr[1:0], i_size)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                    end
`else
                    state_d = S_ACCESS;
`endif
                end
            end
            S_ACCESS: begin
                if (rw_q) begin
                    state_d = S_RESP;
                end else if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                    wait_d  = 2'd0;
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CAPT;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_CAPT:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. The enable is gated by reset directly so that asserting
    // reset during ACCESS suppresses the write in that same cycle.
    always_comb begin
        o_ack     = (state_q == S_RESP);
        o_busy    = (state_q == S_ACCESS) || (state_q == S_WAIT) || (state_q == S_CAPT);
        o_mem_en  = (state_q == S_ACCESS) && i_reset_n;
        o_mem_wen = (state_q == S_ACCESS) && rw_q;
    end

    // Lane mapping: byte k of the request sits in lane (off+k) mod 4; lanes
    // numerically below the offset belong to the following row.
    always_comb begin
        off        = addr_q[1:0];
        row        = addr_q[ADDR_WIDTH-1:2];
        row_n      = row + 1'b1;
        nb         = nbytes(size_q);
        k          = 2'd0;
        lane       = 2'd0;
        lane_row   = '0;
        lane_mask  = 4'd0;
        lane_wdata = 32'd0;
        rd_data    = 32'd0;
        for (int l = 0; l < 4; l++) begin
            k = 2'(l) - off;
            lane_row[l*RW +: RW] = row;
            if ({1'b0, k} < nb) begin
                lane_mask[l]         = 1'b1;
                lane_wdata[8*l +: 8] = dwrite_q[8*k +: 8];
                if (2'(l) < off) begin
                    lane_row[l*RW +: RW] = row_n;
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            lane = off + 2'(j);
            if (3'(j) < nb) begin
                rd_data[8*j +: 8] = i_mem_rdata[8*lane +: 8];
            end
        end
    end

    assign o_mem_addr  = lane_row;
    assign o_mem_wmask = lane_mask;
    assign o_mem_wdata = lane_wdata;
    assign o_dread     = dread_q;

`ifdef HS32_SRAM_ALIGN_CHK_EN
    assign o_err = (state_q == S_RESP) && err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
